// File: rtl/pong_pkg.sv
// Shared definitions for the Pong ball datapath: state encoding, direction
// encoding, paddle-row geometry and the paddle hit test.
package pong_pkg;

  // Ball sequencer states, in the order the debug output reports them.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    MOVE   = 2'd2,
    SCORED = 2'd3
  } ball_state_t;

  // One-bit direction: 0 means +1 pixel per step, 1 means -1 pixel per step.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // Player-0 paddle sits on row 2; player-1 paddle sits 3 rows above the bottom edge.
  localparam int unsigned PADDLE0_ROW        = 2;
  localparam int unsigned PADDLE1_ROW_OFFSET = 3;

  // Reverse a direction.
  function automatic dir_t dir_flip(input dir_t d);
    return (d == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

  // True when ball_x lies on the paddle span [paddle_x, paddle_x+paddle_w-1].
  // The right edge is formed at 9 bits so a paddle near column 255 cannot wrap.
  function automatic logic paddle_hit(input logic [7:0] ball_x,
                                      input logic [7:0] paddle_x,
                                      input logic [8:0] paddle_w);
    logic [8:0] right_edge;
    right_edge = {1'b0, paddle_x} + paddle_w - 9'd1;
    return ({1'b0, ball_x} >= {1'b0, paddle_x}) && ({1'b0, ball_x} <= right_edge);
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running prescaler. Counts 0..PERIOD-1 and raises tick for the single
// cycle in which the count equals PERIOD-1. While clear is high the count is
// held at zero and tick stays low, so releasing clear starts a full period.
module pong_tick_gen #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // Count up, wrapping at the end of each period; clear forces zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencer. Holds the ball while idle or serving, steps it one
// pixel per prescaler tick while moving, bounces it off the side walls and
// both paddles, and emits a one-cycle point pulse when a paddle misses.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SPEED       = 500000,
  parameter int unsigned WIDTH       = 240,
  parameter int unsigned HEIGHT      = 320,
  parameter int unsigned PADDLE_W    = 40,
  parameter int unsigned SERVE_DELAY = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        running,
  input  logic [7:0]  paddle0X,
  input  logic [7:0]  paddle1X,
  output logic [7:0]  ballX,
  output logic [8:0]  ballY,
  output logic        point0,
  output logic        point1,
  output logic        serving,
  output ball_state_t dbg_state
);

  // Geometry derived from the playfield size.
  localparam logic [7:0] X_CENTRE    = 8'(WIDTH / 2);
  localparam logic [8:0] Y_CENTRE    = 9'(HEIGHT / 2);
  localparam logic [7:0] X_LEFT      = 8'd1;
  localparam logic [7:0] X_RIGHT     = 8'(WIDTH - 2);
  localparam logic [8:0] Y_P0_BOUNCE = 9'(PADDLE0_ROW + 1);
  localparam logic [8:0] Y_P1_BOUNCE = 9'(HEIGHT - PADDLE1_ROW_OFFSET - 1);
  localparam logic [8:0] Y_TOP_MISS  = 9'd1;
  localparam logic [8:0] Y_BOT_MISS  = 9'(HEIGHT - 1);
  localparam logic [8:0] PADDLE_SPAN = 9'(PADDLE_W);

  ball_state_t state, state_next;
  logic [7:0]  ball_x, x_next;
  logic [8:0]  ball_y, y_next;
  dir_t        dx, dx_next;
  dir_t        dy, dy_next;
  logic        point0_q, point1_q, serving_q;
  logic        p0_next, p1_next;

  logic        step_tick, serve_tick;
  logic        step_clear, serve_clear;

  logic        flip_x, flip_y;
  dir_t        step_dx, step_dy;
  logic [7:0]  step_x;
  logic [8:0]  step_y;

  // The step prescaler only runs in MOVE, so every entry into MOVE starts a
  // full SPEED-cycle wait before the first step.
  assign step_clear  = (state != MOVE);
  // The serve delay runs in SERVE and SCORED; it is cleared in between, so
  // each hold lasts exactly SERVE_DELAY cycles.
  assign serve_clear = !((state == SERVE) || (state == SCORED));

  pong_tick_gen #(.PERIOD(SPEED)) u_step_gen (
    .clock (clock),
    .reset (reset),
    .clear (step_clear),
    .tick  (step_tick)
  );

  pong_tick_gen #(.PERIOD(SERVE_DELAY)) u_serve_gen (
    .clock (clock),
    .reset (reset),
    .clear (serve_clear),
    .tick  (serve_tick)
  );

  // Candidate next position for a step: wall and paddle flips are decided on
  // the pre-step position, then the position moves by the post-flip direction.
  always_comb begin
    flip_x  = ((ball_x == X_LEFT)  && (dx == DIR_NEG)) ||
              ((ball_x == X_RIGHT) && (dx == DIR_POS));
    flip_y  = ((ball_y == Y_P0_BOUNCE) && (dy == DIR_NEG) &&
               paddle_hit(ball_x, paddle0X, PADDLE_SPAN)) ||
              ((ball_y == Y_P1_BOUNCE) && (dy == DIR_POS) &&
               paddle_hit(ball_x, paddle1X, PADDLE_SPAN));
    step_dx = flip_x ? dir_flip(dx) : dx;
    step_dy = flip_y ? dir_flip(dy) : dy;
    step_x  = (step_dx == DIR_POS) ? (ball_x + 8'd1) : (ball_x - 8'd1);
    step_y  = (step_dy == DIR_POS) ? (ball_y + 9'd1) : (ball_y - 9'd1);
  end

  // Next-state and next-datapath decode. Dropping running wins over every
  // state and returns the ball to its fresh-game position and heading.
  always_comb begin
    state_next = state;
    x_next     = ball_x;
    y_next     = ball_y;
    dx_next    = dx;
    dy_next    = dy;
    p0_next    = 1'b0;
    p1_next    = 1'b0;
    if (!running) begin
      state_next = IDLE;
      x_next     = X_CENTRE;
      y_next     = Y_CENTRE;
      dx_next    = DIR_POS;
      dy_next    = DIR_POS;
    end else begin
      case (state)
        IDLE: begin
          state_next = SERVE;
          x_next     = X_CENTRE;
          y_next     = Y_CENTRE;
        end
        SERVE: begin
          if (serve_tick) begin
            state_next = MOVE;
          end
        end
        MOVE: begin
          if (step_tick) begin
            x_next  = step_x;
            y_next  = step_y;
            dx_next = step_dx;
            dy_next = step_dy;
            if (step_y == Y_TOP_MISS) begin
              p1_next    = 1'b1;
              state_next = SCORED;
            end else if (step_y == Y_BOT_MISS) begin
              p0_next    = 1'b1;
              state_next = SCORED;
            end
          end
        end
        SCORED: begin
          // The frozen row tells who conceded; re-serve toward that player.
          if (serve_tick) begin
            state_next = MOVE;
            x_next     = X_CENTRE;
            y_next     = Y_CENTRE;
            dy_next    = (ball_y == Y_TOP_MISS) ? DIR_NEG : DIR_POS;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ball position, heading and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ball_x    <= X_CENTRE;
      ball_y    <= Y_CENTRE;
      dx        <= DIR_POS;
      dy        <= DIR_POS;
      point0_q  <= 1'b0;
      point1_q  <= 1'b0;
      serving_q <= 1'b0;
    end else begin
      ball_x    <= x_next;
      ball_y    <= y_next;
      dx        <= dx_next;
      dy        <= dy_next;
      point0_q  <= p0_next;
      point1_q  <= p1_next;
      // serving follows the state one cycle behind its entry edge.
      serving_q <= (state == SERVE) || (state == SCORED);
    end
  end

  assign ballX     = ball_x;
  assign ballY     = ball_y;
  assign point0    = point0_q;
  assign point1    = point1_q;
  assign serving   = serving_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: directed trajectory with literal expectations,
// then randomized play, all compared each cycle against a behavioural model.
module tb_pong_ball_ctrl;

  localparam int SPEED       = 4;
  localparam int WIDTH       = 16;
  localparam int HEIGHT      = 20;
  localparam int PADDLE_W    = 4;
  localparam int SERVE_DELAY = 8;

  localparam int PH_IDLE   = 0;
  localparam int PH_SERVE  = 1;
  localparam int PH_MOVE   = 2;
  localparam int PH_SCORED = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       running  = 1'b0;
  logic [7:0] paddle0X = 8'd0;
  logic [7:0] paddle1X = 8'd0;
  logic [7:0] ballX;
  logic [8:0] ballY;
  logic       point0, point1, serving;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  pong_ball_ctrl #(
    .SPEED(SPEED), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .PADDLE_W(PADDLE_W), .SERVE_DELAY(SERVE_DELAY)
  ) dut (
    .clock(clock), .reset(reset), .running(running),
    .paddle0X(paddle0X), .paddle1X(paddle1X),
    .ballX(ballX), .ballY(ballY),
    .point0(point0), .point1(point1), .serving(serving),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Integer position and velocity, phase label, and cycles left until the
  // next hold expiry / ball step.
  int m_x = WIDTH / 2, m_y = HEIGHT / 2, m_vx = 1, m_vy = 1;
  int m_phase = PH_IDLE, m_wait = 0, m_left = 0;
  int e_p0 = 0, e_p1 = 0, e_serving = 0;

  function automatic bit on_paddle(input int x, input int px);
    return (x >= px) && (x <= px + PADDLE_W - 1);
  endfunction

  task automatic model_reset();
    m_x = WIDTH / 2; m_y = HEIGHT / 2; m_vx = 1; m_vy = 1;
    m_phase = PH_IDLE; m_wait = 0; m_left = 0;
    e_p0 = 0; e_p1 = 0; e_serving = 0;
  endtask

  task automatic ball_step();
    bit fx, fy;
    fx = (m_x == 1 && m_vx < 0) || (m_x == WIDTH - 2 && m_vx > 0);
    fy = (m_y == 3 && m_vy < 0 && on_paddle(m_x, int'(paddle0X))) ||
         (m_y == HEIGHT - 4 && m_vy > 0 && on_paddle(m_x, int'(paddle1X)));
    if (fx) m_vx = -m_vx;
    if (fy) m_vy = -m_vy;
    m_x = m_x + m_vx;
    m_y = m_y + m_vy;
    if (m_y == 1) begin
      e_p1 = 1; m_phase = PH_SCORED; m_wait = SERVE_DELAY;
    end else if (m_y == HEIGHT - 1) begin
      e_p0 = 1; m_phase = PH_SCORED; m_wait = SERVE_DELAY;
    end
  endtask

  task automatic model_edge();
    e_serving = (m_phase == PH_SERVE || m_phase == PH_SCORED) ? 1 : 0;
    e_p0 = 0; e_p1 = 0;
    if (!running) begin
      m_x = WIDTH / 2; m_y = HEIGHT / 2; m_vx = 1; m_vy = 1;
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          m_phase = PH_SERVE; m_wait = SERVE_DELAY;
        end
        PH_SERVE: begin
          m_wait--;
          if (m_wait == 0) begin m_phase = PH_MOVE; m_left = SPEED; end
        end
        PH_MOVE: begin
          m_left--;
          if (m_left == 0) begin m_left = SPEED; ball_step(); end
        end
        default: begin
          m_wait--;
          if (m_wait == 0) begin
            m_vy = (m_y == 1) ? -1 : 1;
            m_x = WIDTH / 2; m_y = HEIGHT / 2;
            m_phase = PH_MOVE; m_left = SPEED;
          end
        end
      endcase
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_edge();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("ballX",   32'(ballX),     32'(m_x));
      check("ballY",   32'(ballY),     32'(m_y));
      check("point0",  32'(point0),    32'(e_p0));
      check("point1",  32'(point1),    32'(e_p1));
      check("serving", 32'(serving),   32'(e_serving));
      check("state",   32'(dbg_state), 32'(m_phase));
    end
  end

  // ---------------- driver helpers ----------------
  // Advance n rising edges and return on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic lit_pos(input string name, input int x, input int y);
    check({name, "_x"}, 32'(ballX), 32'(x));
    check({name, "_y"}, 32'(ballY), 32'(y));
  endtask

  function automatic logic [7:0] pick_paddle(input int bx);
    int px;
    case ($urandom_range(0, 4))
      0:       px = int'($urandom_range(0, 255));
      1:       px = bx;
      2:       px = bx - (PADDLE_W - 1);
      3:       px = bx + 1;
      default: px = bx - PADDLE_W;
    endcase
    if (px < 0) px = bx + 1;
    return 8'(px);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    check("rst_ballX",   32'(ballX),   32'd8);
    check("rst_ballY",   32'(ballY),   32'd10);
    check("rst_serving", 32'(serving), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    chk_en   = 1'b1;
    reset    = 1'b1;
    running  = 1'b1;
    paddle0X = 8'd0;
    paddle1X = 8'd12;

    // Serve hold then first step.
    tick(12);  lit_pos("held", 8, 10);
    tick(1);   lit_pos("first_step", 9, 11);
    // Bottom corner: wall and paddle 1 flip together.
    tick(20);  lit_pos("pre_corner_bot", 14, 16);
    tick(4);   lit_pos("corner_bot", 13, 15);
    // Top corner against paddle 0 at column 0.
    tick(48);  lit_pos("pre_corner_top", 1, 3);
    tick(4);   lit_pos("corner_top", 2, 4);
    // Paddle 1 moved away: miss at the bottom, point0 pulses once.
    paddle1X = 8'd0;
    tick(48);  lit_pos("pre_miss", 14, 16);
    tick(12);  lit_pos("miss_row", 11, 19);
    check("miss_point0", 32'(point0), 32'd1);
    tick(1);
    check("miss_point0_end", 32'(point0), 32'd0);
    check("miss_serving",    32'(serving), 32'd1);
    tick(7);   lit_pos("reserve", 8, 10);
    tick(4);   lit_pos("reserve_step", 7, 11);
    // Drop running mid-MOVE.
    tick(2);
    running = 1'b0;
    tick(1);
    lit_pos("drop", 8, 10);
    check("drop_state",  32'(dbg_state), 32'd0);
    check("drop_point0", 32'(point0),    32'd0);
    // Reset mid-SERVE takes effect without a clock edge.
    running = 1'b1;
    tick(3);
    check("pre_rst_serving", 32'(serving), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_serving", 32'(serving),   32'd0);
    check("async_state",   32'(dbg_state), 32'd0);
    lit_pos("async", 8, 10);
    @(negedge clock);
    reset = 1'b1;

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (running) begin
        if ($urandom_range(0, 599) == 0) running = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        running = 1'b1;
      end
      paddle0X = pick_paddle(m_x);
      paddle1X = pick_paddle(m_x);
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_ctrl.md
# pong_ball_ctrl

Sequences the ball datapath for the Pong game. While the game is running, it advances the ball one pixel per prescaler tick and bounces it off the side walls and both paddles. When a paddle misses, it emits a one-cycle point pulse, holds the ball, then re-serves from centre. It sits between the game-state FSM (which supplies `running` and consumes the point pulses) and the video renderer (which consumes `ballX`/`ballY`).

## Interface
- SPEED, 500000: clock cycles per ball step (≥2).
- WIDTH, 240: playfield width in pixels (≤256).
- HEIGHT, 320: playfield height in pixels (≤512).
- PADDLE_W, 40: paddle width in pixels.
- SERVE_DELAY, 50000000: cycles the ball is held before each serve.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- running  in  1  game active; level, from game-state FSM.
- paddle0X  in  8  left edge of player-0 paddle (top, row 2).
- paddle1X  in  8  left edge of player-1 paddle (bottom, row HEIGHT-3).
- ballX  out  8  ball column.
- ballY  out  9  ball row.
- point0  out  1  one-cycle pulse: player 0 scored (ball reached row HEIGHT-1).
- point1  out  1  one-cycle pulse: player 1 scored (ball reached row 1).
- serving  out  1  high in SERVE and SCORED states.

## Operation
- Reset values: ballX=WIDTH/2, ballY=HEIGHT/2, dx=+1, dy=+1 (down), point0=point1=0, serving=0, state IDLE, counters 0.
- States:
  - IDLE: ball held at centre, counters cleared. Goes to SERVE when `running`=1.
  - SERVE: delay counter runs to SERVE_DELAY-1, then goes to MOVE with the tick counter cleared.
  - MOVE: the tick counter counts 0..SPEED-1. On the cycle where it equals SPEED-1 (a step), the position updates as below.
  - SCORED: ball frozen at its scoring row. After SERVE_DELAY cycles, the ball recentres, dy points toward the player who conceded, and the state goes to MOVE.
- `running`=0 in any state → IDLE next cycle, ball recentred, no point pulse.
- Step rules, evaluated on pre-step values; all flips take effect in the same step:
  - X axis: if ballX==1 and dx=-1, or ballX==WIDTH-2 and dx=+1, flip dx.
  - Paddle 0: if ballY==3, dy=-1, and paddle0X ≤ ballX ≤ paddle0X+PADDLE_W-1, flip dy. Compute the bound at 9 bits so it cannot wrap.
  - Paddle 1: if ballY==HEIGHT-4, dy=+1, and the same test holds against paddle1X, flip dy.
  - A corner case (wall and paddle in the same step) flips both dx and dy.
  - The new position is the old position plus the post-flip dx/dy.
- Miss: a step that produces ballY==1 asserts point1 on the same edge that updates ballY, and the state goes to SCORED. A step that produces ballY==HEIGHT-1 asserts point0 the same way. Each pulse lasts exactly one cycle.
- Point pulses never coincide; at most one scoring row is reachable per step.

## Timing
- The first step occurs SPEED cycles after entering MOVE; subsequent steps occur every SPEED cycles.
- Position and point outputs are registered and change only on the step edge.
- Serve latency: SERVE_DELAY cycles in SERVE (or SCORED) plus SPEED cycles to the first movement.
- `serving` is registered and tracks the state with one cycle of latency from the entry edge.
- Reset mid-step forces reset values immediately; no partial update survives.

## Structure
- Shared package `pong_pkg`: ball state enum (IDLE/SERVE/MOVE/SCORED), direction encoding (1 bit: 0=+1, 1=-1), and paddle-row constants (PADDLE0_ROW=2, PADDLE1_ROW offset 3 from HEIGHT).
- One sub-module, `pong_tick_gen`: parametrised prescaler with clear input and single-cycle `tick` output. It is instantiated twice, once for the step counter and once for the serve delay.

## Test plan
Bench parameters: SPEED=4, WIDTH=16, HEIGHT=20, PADDLE_W=4, SERVE_DELAY=8.
- Reset, then `running`=1 → ball stays at (8,10) for 8 cycles; first step 4 cycles later gives (9,11).
- Ball at (14,*) moving +x → next step yields x=13 and dx=-1; at (1,*) moving -x → x=2.
- Ball at (5,3) moving up with paddle0X=4 → next step gives y=4 and dy=+1. With paddle0X=6 (miss) → y=2, then y=1 with a single point1 pulse, state SCORED, ball frozen 8 cycles, recentre to (8,10) with dy=-1.
- Paddle edge inclusive: paddle1X=2, ball at (5,16) moving down → bounce; ball at (6,16) → miss, and point0 pulses when ballY=19.
- Corner: ball at (14,3) moving +x and up with paddle0X=12 → dx and dy both flip in one step, giving (13,4).
- Drop `running` mid-MOVE → IDLE next cycle, ball at (8,10), no point pulse. Assert reset mid-SERVE → all outputs at reset values immediately.
